// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the vector-path reducers.
// Latency: n/a (types only).
// Backpressure: n/a.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam fp32_t FP32_POS_ZERO = '{sign: 1'b0, exp: 8'h00, mant: 23'h0};
    localparam fp32_t FP32_NEG_ZERO = '{sign: 1'b1, exp: 8'h00, mant: 23'h0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pool_state_e;

endpackage

// File: rtl/fp32_min_cmp.sv
// Combinational FP32 minimum of a and b, sign-magnitude ordering; ties favour a.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module fp32_min_cmp
    import fp32_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t min_out,
    output logic  a_wins
);

    logic [30:0] mag_a;
    logic [30:0] mag_b;
    logic        both_zero;

    assign mag_a     = {a.exp, a.mant};
    assign mag_b     = {b.exp, b.mant};
    // +0 and -0 are equal regardless of sign
    assign both_zero = (mag_a == 31'd0) && (mag_b == 31'd0);

    // a wins when a <= b; NaN/Inf fall through as plain bit patterns
    always_comb begin
        a_wins = 1'b0;
        if (both_zero) begin
            a_wins = 1'b1;
        end else if (a.sign != b.sign) begin
            a_wins = a.sign;
        end else if (!a.sign) begin
            a_wins = (mag_a <= mag_b);
        end else begin
            a_wins = (mag_a >= mag_b);
        end
    end

    assign min_out = a_wins ? a : b;

endmodule

// File: rtl/fp32_min_pool.sv
// Streaming FP32 min-pool: reduces every WINDOW accepted elements to one minimum.
// Latency: result valid the cycle after the last element is accepted; one window per WINDOW+1 cycles.
// Backpressure: holds result (in_ready=0) until out_ready; no overlap with next window.
// Optional: define FP32_MIN_POOL_ARGMIN_EN to add out_index (position of the minimum).
module fp32_min_pool
    import fp32_pkg::*;
#(
    parameter  int WINDOW = 4,
    localparam int CNT_W  = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
`ifdef FP32_MIN_POOL_ARGMIN_EN
    output logic [CNT_W-1:0] out_index,
`endif
    output logic             busy
);

    pool_state_e      state;
    logic [CNT_W-1:0] count;
    fp32_t            acc;
    fp32_t            cmp_min;
    logic             acc_wins;
    logic             accept;
    logic             deliver;
    logic             last_elem;

`ifdef FP32_MIN_POOL_ARGMIN_EN
    logic [CNT_W-1:0] idx;
    assign out_index = idx;
`endif

    fp32_min_cmp u_cmp (
        .a       (acc),
        .b       (fp32_t'(in_data)),
        .min_out (cmp_min),
        .a_wins  (acc_wins)
    );

    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    // count equals the 0-based position of the element being accepted
    assign last_elem = (count == CNT_W'(WINDOW - 1));
    assign out_data  = acc;

    // Reduction FSM; in_ready/out_valid/busy are registered with the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= FP32_POS_ZERO;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef FP32_MIN_POOL_ARGMIN_EN
            idx       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= fp32_t'(in_data);
                        count <= CNT_W'(1);
                        busy  <= 1'b1;
`ifdef FP32_MIN_POOL_ARGMIN_EN
                        idx   <= '0;
`endif
                        if (WINDOW == 1) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // only a strictly smaller element replaces the earlier one
                        if (!acc_wins) begin
                            acc <= cmp_min;
`ifdef FP32_MIN_POOL_ARGMIN_EN
                            idx <= count;
`endif
                        end
                        count <= count + CNT_W'(1);
                        if (last_elem) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (deliver) begin
                        state     <= IDLE;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
